// File: rtl/super_pkg.sv
// Shared types and word-geometry constants for the data-memory responder.
// Grant FSM states and the response pipeline stage record live here.
package super_pkg;

   localparam int MemW  = 32;
   localparam int TagW  = 1;
   localparam int WordW = MemW + TagW;
   localparam int BeW   = MemW / 8;

   typedef enum logic {
      GS_IDLE,
      GS_WAIT
   } gnt_state_e;

   typedef struct packed {
      logic valid;
      logic err;
      logic is_wr;
   } resp_stage_t;

endpackage

// File: rtl/dmem_responder_if.sv
// LSU-side data bus bundle: request channel from master, grant and
// response channel back from the slave.
interface dmem_responder_if
   import super_pkg::*;
;

   logic             req;
   logic             gnt;
   logic             we;
   logic [BeW-1:0]   be;
   logic [31:0]      addr;
   logic [WordW-1:0] wdata;
   logic             rvalid;
   logic [WordW-1:0] rdata;
   logic             err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/dmem_sram.sv
// Single-port byte-enabled 33-bit SRAM with registered read and a
// tag-clear input for partial writes. Contents are never reset.
module dmem_sram
   import super_pkg::*;
#(
   parameter int Depth = 1024,
   parameter int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [BeW-1:0]   be,
   input  logic [AddrW-1:0] addr,
   input  logic [WordW-1:0] wdata,
   input  logic             tag_clr,
   output logic [WordW-1:0] rdata
);

   logic [WordW-1:0] mem [Depth];

   // Byte-merged write, full-word tag update, or registered read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BeW; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
            if (&be) begin
               mem[addr][MemW] <= wdata[MemW];
            end else if (tag_clr) begin
               mem[addr][MemW] <= 1'b0;
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: delayed grant FSM, SRAM access, and a fixed
// latency in-order response pipeline with range checking.
module dmem_responder
   import super_pkg::*;
#(
   parameter int MemDepth = 1024,
   parameter int GntDly   = 0,
   parameter int RespDly  = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             data_req_i,
   output logic             data_gnt_o,
   input  logic             data_we_i,
   input  logic [BeW-1:0]   data_be_i,
   input  logic [31:0]      data_addr_i,
   input  logic [WordW-1:0] data_wdata_i,
   output logic             data_rvalid_o,
   output logic [WordW-1:0] data_rdata_o,
   output logic             data_err_o
);

   localparam int AddrW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

   gnt_state_e       state, state_n;
   logic [2:0]       wait_cnt, wait_cnt_n;
   logic             gnt;
   logic             in_range;
   logic             tag_clr;
   logic [WordW-1:0] sram_rdata;
   resp_stage_t      st0;
   resp_stage_t      st_out;
   logic [WordW-1:0] dat_out;
   logic             unused_lsb;

   assign unused_lsb = ^data_addr_i[1:0];

   // Grant FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= GS_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
      end
   end

   // Grant FSM next state; grant is suppressed while in reset.
   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      gnt        = 1'b0;
      if (!rst_i) begin
         unique case (state)
            GS_IDLE: begin
               if (data_req_i) begin
                  if (GntDly == 0) begin
                     gnt = 1'b1;
                  end else begin
                     state_n    = GS_WAIT;
                     wait_cnt_n = 3'd1;
                  end
               end
            end
            GS_WAIT: begin
               if (!data_req_i) begin
                  state_n    = GS_IDLE;
                  wait_cnt_n = '0;
               end else if (wait_cnt == 3'(GntDly)) begin
                  gnt        = 1'b1;
                  state_n    = GS_IDLE;
                  wait_cnt_n = '0;
               end else begin
                  wait_cnt_n = wait_cnt + 3'd1;
               end
            end
         endcase
      end
   end

   assign data_gnt_o = gnt;
   assign in_range   = {2'b00, data_addr_i[31:2]} < MemDepth;
   assign tag_clr    = (data_be_i != '1) && (data_be_i != '0);

   dmem_sram #(
      .Depth (MemDepth),
      .AddrW (AddrW)
   ) u_sram (
      .clk     (clk_i),
      .en      (gnt & in_range),
      .we      (data_we_i),
      .be      (data_be_i),
      .addr    (data_addr_i[AddrW+1:2]),
      .wdata   (data_wdata_i),
      .tag_clr (tag_clr),
      .rdata   (sram_rdata)
   );

   // First response stage, aligned with the SRAM read latency.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st0 <= '0;
      end else begin
         st0 <= '{valid: gnt,
                  err:   gnt & ~in_range,
                  is_wr: gnt & data_we_i};
      end
   end

   if (RespDly == 0) begin : g_nodly
      assign st_out  = st0;
      assign dat_out = sram_rdata;
   end else begin : g_dly
      resp_stage_t      st_pipe  [RespDly];
      logic [WordW-1:0] dat_pipe [RespDly];

      // Stage records shift; valids drop on reset.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int i = 0; i < RespDly; i++) begin
               st_pipe[i] <= '0;
            end
         end else begin
            st_pipe[0] <= st0;
            for (int i = 1; i < RespDly; i++) begin
               st_pipe[i] <= st_pipe[i-1];
            end
         end
      end

      // Read data follows its stage record; masked at the output.
      always_ff @(posedge clk_i) begin
         dat_pipe[0] <= sram_rdata;
         for (int i = 1; i < RespDly; i++) begin
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end

      assign st_out  = st_pipe[RespDly-1];
      assign dat_out = dat_pipe[RespDly-1];
   end

   assign data_rvalid_o = st_out.valid & ~rst_i;
   assign data_err_o    = data_rvalid_o & st_out.err;
   assign data_rdata_o  =
      (data_rvalid_o & ~st_out.err & ~st_out.is_wr) ? dat_out : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three parameterisations share one stimulus
// stream and are each checked against a behavioural model.
module tb_dmem_responder;
   import super_pkg::*;

   localparam int GD [3] = '{0, 0, 3};
   localparam int RD [3] = '{0, 3, 2};
   localparam int MD [3] = '{1024, 64, 64};

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [32:0] wdata;

   always #5 clk = ~clk;

   dmem_responder_if bus_a ();
   dmem_responder_if bus_b ();
   dmem_responder_if bus_c ();

   assign {bus_a.req, bus_a.we, bus_a.be, bus_a.addr, bus_a.wdata} =
          {req, we, be, addr, wdata};
   assign {bus_b.req, bus_b.we, bus_b.be, bus_b.addr, bus_b.wdata} =
          {req, we, be, addr, wdata};
   assign {bus_c.req, bus_c.we, bus_c.be, bus_c.addr, bus_c.wdata} =
          {req, we, be, addr, wdata};

   dmem_responder #(.MemDepth(1024), .GntDly(0), .RespDly(0)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(bus_a.req), .data_gnt_o(bus_a.gnt),
      .data_we_i(bus_a.we), .data_be_i(bus_a.be),
      .data_addr_i(bus_a.addr), .data_wdata_i(bus_a.wdata),
      .data_rvalid_o(bus_a.rvalid), .data_rdata_o(bus_a.rdata),
      .data_err_o(bus_a.err)
   );

   dmem_responder #(.MemDepth(64), .GntDly(0), .RespDly(3)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(bus_b.req), .data_gnt_o(bus_b.gnt),
      .data_we_i(bus_b.we), .data_be_i(bus_b.be),
      .data_addr_i(bus_b.addr), .data_wdata_i(bus_b.wdata),
      .data_rvalid_o(bus_b.rvalid), .data_rdata_o(bus_b.rdata),
      .data_err_o(bus_b.err)
   );

   dmem_responder #(.MemDepth(64), .GntDly(3), .RespDly(2)) dut_c (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(bus_c.req), .data_gnt_o(bus_c.gnt),
      .data_we_i(bus_c.we), .data_be_i(bus_c.be),
      .data_addr_i(bus_c.addr), .data_wdata_i(bus_c.wdata),
      .data_rvalid_o(bus_c.rvalid), .data_rdata_o(bus_c.rdata),
      .data_err_o(bus_c.err)
   );

   logic [2:0]  o_gnt, o_rv, o_err;
   logic [32:0] o_rd [3];

   assign o_gnt = {bus_c.gnt, bus_b.gnt, bus_a.gnt};
   assign o_rv  = {bus_c.rvalid, bus_b.rvalid, bus_a.rvalid};
   assign o_err = {bus_c.err, bus_b.err, bus_a.err};
   assign o_rd[0] = bus_a.rdata;
   assign o_rd[1] = bus_b.rdata;
   assign o_rd[2] = bus_c.rdata;

   // Model state: consecutive-request count, memory image, and a
   // response timeline indexed by the cycle a response is due.
   int          cnt   [3];
   logic [32:0] mem   [3][1024];
   bit          known [3][1024];
   bit          sv    [3][8];
   bit          se    [3][8];
   bit          sk    [3][8];
   logic [32:0] sd    [3][8];

   bit          s_gnt [3];
   bit          s_rv  [3];
   bit          s_er  [3];
   logic [32:0] s_rd  [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input int d,
                      input logic [32:0] got, input logic [32:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h",
                  nm, d, cyc, got, exp);
      end
   endtask

   task automatic step();
      int        sl;
      int        ds;
      int        w;
      bit        inr;
      bit        eg;
      bit        ev;
      @(negedge clk);
      sl = cyc % 8;
      w  = int'(addr[31:2]);
      for (int d = 0; d < 3; d++) begin
         inr = w < MD[d];
         eg  = !rst && req && (cnt[d] == GD[d]);
         ev  = !rst && sv[d][sl];
         s_gnt[d] = o_gnt[d];
         s_rv[d]  = o_rv[d];
         s_er[d]  = o_err[d];
         s_rd[d]  = o_rd[d];
         chk("gnt", d, 33'(o_gnt[d]), 33'(eg));
         chk("rvalid", d, 33'(o_rv[d]), 33'(ev));
         chk("err", d, 33'(o_err[d]), 33'(ev && se[d][sl]));
         if (!ev || sk[d][sl]) begin
            chk("rdata", d, o_rd[d], ev ? sd[d][sl] : 33'h0);
         end
         sv[d][sl] = 1'b0;
         if (rst) begin
            cnt[d] = 0;
            for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
         end else if (!req) begin
            cnt[d] = 0;
         end else if (!eg) begin
            cnt[d]++;
         end else begin
            cnt[d] = 0;
            ds = (cyc + 1 + RD[d]) % 8;
            sv[d][ds] = 1'b1;
            se[d][ds] = !inr;
            sk[d][ds] = we || !inr || (inr && known[d][w % 1024]);
            sd[d][ds] = (we || !inr) ? 33'h0 : mem[d][w % 1024];
            if (we && inr) begin
               if (be == 4'hF) begin
                  mem[d][w]   = wdata;
                  known[d][w] = 1'b1;
               end else if (be != 4'h0) begin
                  for (int b = 0; b < 4; b++) begin
                     if (be[b]) mem[d][w][8*b +: 8] = wdata[8*b +: 8];
                  end
                  mem[d][w][32] = 1'b0;
               end
            end
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [32:0] wdata;
      logic [32:0] rd;
      bit          er;
   } vec_t;

   vec_t        tv [14];
   logic [32:0] bdat [4];
   int          nrv;
   int          r;

   initial begin
      tv[0]  = '{1, 4'hF, 32'h40,   33'h1_DEADBEEF, 33'h0,          0};
      tv[1]  = '{0, 4'hF, 32'h40,   33'h0,          33'h1_DEADBEEF, 0};
      tv[2]  = '{1, 4'h2, 32'h40,   33'h0_0000AB00, 33'h0,          0};
      tv[3]  = '{0, 4'h0, 32'h42,   33'h0,          33'h0_DEADABEF, 0};
      tv[4]  = '{1, 4'hF, 32'h0,    33'h0_11111111, 33'h0,          0};
      tv[5]  = '{0, 4'hF, 32'h1000, 33'h0,          33'h0,          1};
      tv[6]  = '{1, 4'hF, 32'h1000, 33'h1_FFFFFFFF, 33'h0,          1};
      tv[7]  = '{0, 4'hF, 32'h0,    33'h0,          33'h0_11111111, 0};
      tv[8]  = '{0, 4'hF, 32'h40,   33'h0,          33'h0_DEADABEF, 0};
      tv[9]  = '{1, 4'hF, 32'h44,   33'h0_12345678, 33'h0,          0};
      tv[10] = '{1, 4'h0, 32'h44,   33'h1_FFFFFFFF, 33'h0,          0};
      tv[11] = '{0, 4'hF, 32'h44,   33'h0,          33'h0_12345678, 0};
      tv[12] = '{1, 4'h9, 32'h44,   33'h1_AA0000BB, 33'h0,          0};
      tv[13] = '{0, 4'h5, 32'h47,   33'h0,          33'h0_AA3456BB, 0};

      rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0;
      addr = 32'h0; wdata = 33'h0;
      step();
      step();
      rst = 1'b0;
      step();

      // Single-cycle accesses on the zero-delay instance.
      for (int i = 0; i < 14; i++) begin
         req = 1'b1; we = tv[i].we; be = tv[i].be;
         addr = tv[i].addr; wdata = tv[i].wdata;
         step();
         chk("tv_gnt", 0, 33'(s_gnt[0]), 33'h1);
         req = 1'b0;
         step();
         chk("tv_rvalid", 0, 33'(s_rv[0]), 33'h1);
         chk("tv_rdata", 0, s_rd[0], tv[i].rd);
         chk("tv_err", 0, 33'(s_er[0]), 33'(tv[i].er));
      end

      // Read granted right after a write to the same word.
      req = 1'b1; we = 1'b1; be = 4'hF;
      addr = 32'h48; wdata = 33'h0_CAFEF00D;
      step();
      we = 1'b0;
      step();
      chk("wr_rsp", 0, s_rd[0], 33'h0);
      req = 1'b0;
      step();
      chk("raw_rdata", 0, s_rd[0], 33'h0_CAFEF00D);
      step();

      // Grant delay: abandoned request, then a full wait.
      req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("dly_gnt_a", 2, 33'(s_gnt[2]), 33'h0);
      end
      req = 1'b0;
      step();
      chk("dly_gnt_drop", 2, 33'(s_gnt[2]), 33'h0);
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dly_gnt_b", 2, 33'(s_gnt[2]), 33'(i == 3));
         chk("dly_norv", 2, 33'(s_rv[2]), 33'h0);
      end
      req = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // Back-to-back writes, then reads in flight across a reset.
      req = 1'b1; we = 1'b1; be = 4'hF;
      for (int i = 0; i < 4; i++) begin
         bdat[i] = {1'(i & 1), 32'h5A00_0000 + 32'(i * 17)};
         addr = 32'(i * 4); wdata = bdat[i];
         step();
      end
      req = 1'b0;
      for (int i = 0; i < 5; i++) step();
      req = 1'b1; we = 1'b0;
      for (int i = 0; i < 2; i++) begin
         addr = 32'(i * 4);
         step();
      end
      req = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rst_drop", 1, 33'(s_rv[1]), 33'h0);
      end
      req = 1'b1; we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr = 32'(i * 4);
         step();
         chk("b2b_gnt", 1, 33'(s_gnt[1]), 33'h1);
      end
      req = 1'b0;
      nrv = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (s_rv[1]) begin
            if (nrv < 4) chk("b2b_data", 1, s_rd[1], bdat[nrv]);
            nrv++;
         end
      end
      chk("b2b_count", 1, 33'(nrv), 33'd4);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         req = ($urandom_range(0, 9) < 7);
         we  = 1'($urandom_range(0, 1));
         be  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         wdata = {1'($urandom_range(0, 1)), 32'($urandom)};
         r = $urandom_range(0, 9);
         if (r < 7) begin
            addr = {30'($urandom_range(0, 15)), 2'($urandom)};
         end else if (r == 7) begin
            addr = {30'(64 + $urandom_range(0, 15)), 2'($urandom)};
         end else if (r == 8) begin
            addr = {30'(1024 + $urandom_range(0, 3)), 2'($urandom)};
         end else begin
            addr = 32'($urandom);
         end
         step();
      end
      rst = 1'b0; req = 1'b0;
      for (int i = 0; i < 6; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MemDepth, default 1024, giving the backing store size in 33-bit words.
REQ-002 SHALL have parameter GntDly, default 0, range 0..7, giving wait cycles before grant.
REQ-003 SHALL have parameter RespDly, default 0, range 0..3, giving extra response cycles after the fixed one-cycle SRAM latency.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_req_i, input, 1 bit: request valid from the LSU.
REQ-007 SHALL have port data_gnt_o, output, 1 bit: request accepted this cycle.
REQ-008 SHALL have port data_we_i, input, 1 bit: 1 for write, 0 for read.
REQ-009 SHALL have port data_be_i, input, 4 bits: byte enables.
REQ-010 SHALL have port data_addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-011 SHALL have port data_wdata_i, input, 33 bits: write data; bit 32 is the capability tag.
REQ-012 SHALL have port data_rvalid_o, output, 1 bit: response valid, never back-pressured.
REQ-013 SHALL have port data_rdata_o, output, 33 bits: read data and tag.
REQ-014 SHALL have port data_err_o, output, 1 bit: response error, qualified by data_rvalid_o.

Function
REQ-015 Grant FSM SHALL have two states.
- GS_IDLE: with data_req_i=1 and GntDly=0, data_gnt_o=1 combinationally and the state stays GS_IDLE. With GntDly>0, the FSM moves to GS_WAIT with wait_cnt=1.
- GS_WAIT: wait_cnt increments each cycle data_req_i=1. data_gnt_o=1 when wait_cnt==GntDly, then the FSM returns to GS_IDLE with wait_cnt=0.
REQ-016 If data_req_i drops in GS_WAIT before grant, the FSM SHALL return to GS_IDLE, clear wait_cnt, and issue no access.
REQ-017 An access occurs only in a grant cycle. It is out of range when data_addr_i[31:2] >= MemDepth; it is in range otherwise.
REQ-018 An out-of-range access SHALL not touch the SRAM and SHALL respond with data_err_o=1 and data_rdata_o=0.
REQ-019 A write with data_be_i==4'hF SHALL store data_wdata_i[31:0] and tag=data_wdata_i[32].
REQ-020 A write with any other nonzero data_be_i SHALL update only the enabled bytes and SHALL clear the stored tag.
REQ-021 A write with data_be_i==0 SHALL leave the word and tag unchanged and still respond.
REQ-022 A read SHALL return the full 33-bit word regardless of data_be_i.
REQ-023 Every granted access SHALL produce exactly one data_rvalid_o pulse, exactly 1+RespDly cycles after its grant cycle.
REQ-024 Responses SHALL be in grant order. Up to 1+RespDly accesses may be outstanding, and back-to-back grants SHALL be sustained at one per cycle.
REQ-025 A write response SHALL have data_rdata_o=0 and data_err_o=0 (in range).
REQ-026 When data_rvalid_o=0, data_rdata_o and data_err_o SHALL be 0.
REQ-027 A read granted the cycle after a write to the same word SHALL return the newly written value (write-then-read ordering).

Reset
REQ-028 While rst_i=1:
- the FSM SHALL be GS_IDLE and wait_cnt 0;
- all response-pipeline valids SHALL clear;
- data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0.
REQ-029 Responses in flight at reset SHALL be dropped. A write coinciding with rst_i=1 SHALL be suppressed.
REQ-030 SRAM contents SHALL NOT be reset.

Structure
REQ-031 The grant FSM enum (GS_IDLE, GS_WAIT) and the response pipeline stage struct (valid, err, is_wr) SHALL live in super_pkg. The 33-bit word width SHALL reuse MemW-derived constants there.
REQ-032 The storage SHALL be one sub-module, dmem_sram: single port, byte-enabled, 33-bit, one-cycle registered read, with a tag-clear input.
REQ-033 The response delay SHALL be a RespDly-deep shift pipeline of stage structs plus a 33-bit data pipeline.

Verification
REQ-034 GntDly=0, RespDly=0: write 0x1_DEADBEEF (be=F) to 0x40, then read 0x40 → gnt same cycle each, rvalid next cycle each, read rdata=0x1_DEADBEEF.
REQ-035 Word 0x40 tagged, write byte be=4'b0010 wdata=0x0_0000AB00, read → rdata=0x0_DEADABEF, tag=0.
REQ-036 GntDly=3: hold req for 2 cycles, drop, then re-request → no gnt and no rvalid at first; gnt on the 4th cycle of the second request.
REQ-037 RespDly=2: four back-to-back reads of 0x0, 0x4, 0x8, 0xC → four grants on consecutive cycles, rvalids 3 cycles later in the same order with the matching data.
REQ-038 MemDepth=1024: read 0x1000 → rvalid with err=1, rdata=0; a following write to 0x1000 leaves memory unchanged.
REQ-039 RespDly=3: two reads outstanding, assert rst_i for one cycle → no rvalid afterwards; FSM idle; memory contents preserved on re-read.
